// File: rtl/program_counter_if.sv
// Bus-side signal bundle for the program counter: control, flags, shared bus and status.
interface program_counter_if #(
  parameter int unsigned ADDR_WIDTH = 4
);
  logic                  count_enable;
  logic                  jump;
  logic                  jump_carry;
  logic                  jump_zero;
  logic                  carry_flag;
  logic                  zero_flag;
  logic                  halt;
  logic                  write_to_bus;
  logic [7:0]            bus_in;
  logic [7:0]            bus_out;
  logic [ADDR_WIDTH-1:0] value;
  logic                  halted;
  logic                  wrapped;

  modport master (
    output count_enable, jump, jump_carry, jump_zero, carry_flag, zero_flag,
           halt, write_to_bus, bus_in,
    input  bus_out, value, halted, wrapped
  );

  modport slave (
    input  count_enable, jump, jump_carry, jump_zero, carry_flag, zero_flag,
           halt, write_to_bus, bus_in,
    output bus_out, value, halted, wrapped
  );
endinterface

// File: rtl/program_counter.sv
// Fetch-address counter: increments, loads jump targets from the shared bus,
// freezes on a sticky halt, and drives its address onto the OR-bus when enabled.
module program_counter #(
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  program_counter_if.slave       pc
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] value_q, value_d;
  logic                  wrapped_q, wrapped_d;
  logic                  take;
  logic [7:0]            value_ext;

  assign take = pc.jump
              | (pc.jump_carry & pc.carry_flag)
              | (pc.jump_zero  & pc.zero_flag);

  always_comb begin
    state_d   = state_q;
    value_d   = value_q;
    wrapped_d = 1'b0;
    case (state_q)
      RUN: begin
        // halt wins over any jump/count requested in the same cycle
        if (pc.halt) begin
          state_d = HALT;
        end else if (take) begin
          value_d = pc.bus_in[ADDR_WIDTH-1:0];
        end else if (pc.count_enable) begin
          value_d   = value_q + 1'b1;
          wrapped_d = &value_q;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      value_q   <= '0;
      wrapped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      value_q   <= value_d;
      wrapped_q <= wrapped_d;
    end
  end

  // Zero-extend through a variable so ADDR_WIDTH=8 needs no zero-width fill.
  always_comb begin
    value_ext                 = '0;
    value_ext[ADDR_WIDTH-1:0] = value_q;
  end

  assign pc.bus_out = pc.write_to_bus ? value_ext : '0;
  assign pc.value   = value_q;
  assign pc.halted  = (state_q == HALT);
  assign pc.wrapped = wrapped_q;

endmodule

// File: doc/program_counter.md
# program_counter

Instruction-address source for the 8-bit CPU: holds the current fetch address and drives it onto the shared 8-bit bus when enabled. It supports increment, unconditional and flag-conditional jumps loaded from the bus, and a sticky halt. It sits on the bus as a source: it presents a value that bus registers latch. The bus is the OR of all source outputs, so an inactive source must output 8'h00.

## Interface
Parameters:
- ADDR_WIDTH, default 4: address width. Legal range 1..8. Upper bus bits are zero-filled.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- count_enable  input  1  increment the address this cycle.
- jump  input  1  unconditional load from bus.
- jump_carry  input  1  load from bus if carry_flag is 1.
- jump_zero  input  1  load from bus if zero_flag is 1.
- carry_flag  input  1  ALU carry flag (registered elsewhere).
- zero_flag  input  1  ALU zero flag (registered elsewhere).
- halt  input  1  request to freeze the counter permanently until reset.
- write_to_bus  input  1  drive the address onto the bus.
- bus_in  input  8  bus value; bits [ADDR_WIDTH-1:0] are the jump target.
- bus_out  output  8  {zeros, value} when write_to_bus is 1, else 8'h00.
- value  output  ADDR_WIDTH  current address, always visible for debug/LEDs.
- halted  output  1  sticky halt status.
- wrapped  output  1  one-cycle pulse, registered: the last increment went from all-ones to zero.

## Operation
- Jump taken: take = jump | (jump_carry & carry_flag) | (jump_zero & zero_flag).
- Next-state priority, highest first:
  1. rst: value=0, halted=0, wrapped=0.
  2. halted==1: hold value; wrapped=0.
  3. halt==1: set halted=1; value holds; the jump or count requested in this cycle is discarded; wrapped=0.
  4. take: value=bus_in[ADDR_WIDTH-1:0]; wrapped=0. A jump beats count_enable in the same cycle.
  5. count_enable: value=value+1 modulo 2^ADDR_WIDTH. wrapped=1 only when the old value was all-ones, else 0.
  6. Otherwise: hold; wrapped=0.
- Two states: RUN (halted=0) and HALT (halted=1).
  - RUN→HALT on halt.
  - HALT→RUN only on rst.
  - Control inputs are ignored in HALT.
- bus_out is combinational from write_to_bus and the registered value. It is not gated by halted; a halted counter can still be read.
- Bits of bus_in above ADDR_WIDTH are ignored on a jump.
- Flags are sampled in the same cycle as jump_carry/jump_zero. A flag without its jump enable has no effect.

## Timing
- Reset values: value=0, halted=0, wrapped=0. bus_out=8'h00 while write_to_bus=0.
- Latency:
  - Increment or jump is visible on value and bus_out one cycle after the edge that samples it.
  - wrapped is high for exactly the cycle after the wrapping edge.
  - halted rises one cycle after halt is sampled.
- bus_out follows write_to_bus with zero-cycle (combinational) latency.
- Self-loop: write_to_bus=1 with jump=1 is legal. The PC reloads its own value, and count_enable in that cycle is lost.
- Reset mid-operation overrides every other input at that edge, including halt, jump and count_enable.
- Holding count_enable continuously increments once per cycle, with no stall.

## Test plan
- Reset then count: rst for 1 cycle, then count_enable=1 for 17 cycles (ADDR_WIDTH=4) → value goes 0,1,…,15,0,1; wrapped pulses exactly once, in the cycle value shows 0.
- Jump vs count: value=3, jump=1, count_enable=1, bus_in=8'hA9 → value=9 next cycle; wrapped=0. With write_to_bus=1, bus_out=8'h09.
- Conditional jumps: bus_in=8'h05.
  - jump_carry=1, carry_flag=0 → no load.
  - Then carry_flag=1 → value=5.
  - jump_zero=1, zero_flag=1, bus_in=8'h0C → value=12.
  - zero_flag=1 with jump_zero=0 → no load.
- Bus gating: value=7, write_to_bus=0 → bus_out=8'h00; write_to_bus=1 → bus_out=8'h07 in the same cycle.
- Halt: at value=6, halt=1 with jump=1, bus_in=8'h02.
  - Required: value stays 6 and halted=1 next cycle.
  - Following count_enable and jump pulses leave value=6.
  - bus_out=8'h06 when write_to_bus=1.
- Reset while halted and counting: halted=1, count_enable=1, rst=1 → next cycle value=0, halted=0, wrapped=0; counting resumes the cycle after rst drops.
